zjh_timer_arb: RTL and testbench
================================

ZJH_TIMER_ARB -- requirements
Module: zjh_timer_arb

Interface
REQ-001 The block SHALL have parameter N_REQ, default 4, giving the number of requesters (fixed range 2..4).
REQ-002 The block SHALL have parameter CNT_W, default 4, giving the duration and counter width.
REQ-003 The block SHALL have port Clk, input, 1, the single clock; all state changes on rising edge.
REQ-004 The block SHALL have port MR_N, input, 1, the master reset: asynchronous, active-low.
REQ-005 The block SHALL have port Req, input, N_REQ, one request bit per requester, level-held for the whole grant.
REQ-006 The block SHALL have port Dur, input, N_REQ*CNT_W, the packed per-requester hold durations; slice i is Dur[i*CNT_W +: CNT_W].
REQ-007 The block SHALL have port Gnt, output, N_REQ, a one-hot grant (all-zero when idle).
REQ-008 The block SHALL have port Gnt_id, output, 2, the binary index of the current/last winner.
REQ-009 The block SHALL have port Cnt, output, CNT_W, the remaining-count value of the shared counter.
REQ-010 The block SHALL have port Busy, output, 1, high while in RUN.
REQ-011 The block SHALL have port Done, output, 1, a one-cycle pulse on normal grant completion.

Function
REQ-012 The FSM SHALL have exactly two states: IDLE and RUN.
REQ-013 In IDLE with Req nonzero, the next edge SHALL enter RUN, set Gnt to the winner's one-hot, set Gnt_id, and load Cnt with the winner's Dur slice.
REQ-014 In RUN with Req[Gnt_id]=1 and Cnt!=0, each edge SHALL decrement Cnt by 1 (no wrap).
REQ-015 In RUN with Req[Gnt_id]=1 and Cnt==0, the edge SHALL return to IDLE, clear Gnt, and set Done=1 for exactly one cycle; the grant therefore lasts Dur+1 cycles.
REQ-016 In RUN with Req[Gnt_id]=0 (abort), the edge SHALL return to IDLE, clear Gnt and Cnt, and leave Done at 0.
REQ-017 Dur=0 SHALL yield a one-cycle grant followed by Done.
REQ-018 At least one IDLE cycle SHALL separate consecutive grants; arbitration SHALL occur only in IDLE.
REQ-019 Changes to Dur or to non-granted Req bits during RUN SHALL have no effect on the current grant.
REQ-020 Gnt SHALL never have more than one bit set.
REQ-021 Busy SHALL equal (state==RUN) and be registered.
REQ-022 Gnt_id SHALL hold its value in IDLE.

Reset
REQ-023 While MR_N=0, the block SHALL be in IDLE with Gnt=0, Gnt_id=0, Cnt=0, Busy=0, Done=0, and the RR pointer=N_REQ-1, taking effect immediately without a clock.
REQ-024 Reset asserted mid-RUN SHALL abort without a Done pulse; the first grant after release SHALL follow REQ-023 state.

Configuration
REQ-025 With ZJH_TIMER_ARB_RR_EN defined, arbitration SHALL be round-robin: search starts at pointer+1 modulo N_REQ, and the pointer SHALL update to the winner on each grant.
REQ-026 Without ZJH_TIMER_ARB_RR_EN, arbitration SHALL be fixed priority with Req[0] highest, and no pointer register SHALL exist.

Structure
REQ-027 A shared package SHALL hold the state encoding (IDLE=1'b0, RUN=1'b1) and the default N_REQ/CNT_W constants.
REQ-028 The shared counter SHALL be a sub-module zjh_cnt_dn (synchronous load, enable-decrement, async active-low clear, zero flag); the arbiter and FSM SHALL be in the top module.

Verification
REQ-029 Reset test: drive MR_N=0 mid-RUN with Cnt=5 -> Gnt=0, Cnt=0, Busy=0 immediately, and no Done.
REQ-030 Single request test: Req=0001, Dur0=3 -> Gnt=0001 for 4 cycles with Cnt 3,2,1,0, then Done=1 for one cycle, then Gnt=0.
REQ-031 Contention test with RR_EN: Req=1111 held, all Dur=0 -> grant order 0,1,2,3,0, with one IDLE cycle between grants.
REQ-032 Contention test without RR_EN: Req=1111 held -> every grant goes to requester 0; drop Req[0] -> next grant goes to requester 1.
REQ-033 Abort test: Req=0100, Dur2=9; drop Req[2] when Cnt=6 -> next cycle IDLE, Gnt=0, Cnt=0, Done=0.
REQ-034 Boundary test: Dur=15 (max) -> grant lasts 16 cycles with no wrap; Dur changed mid-RUN -> Cnt sequence unaffected.

Source files
------------

// File: rtl/zjh_timer_arb_pkg.sv
// ---------------------------------------------------------------------------
// zjh_timer_arb_pkg
// Shared definitions for the timed arbiter:
//   state_t        - two-state FSM encoding (IDLE=0, RUN=1)
//   N_REQ_DEF      - default number of requesters
//   CNT_W_DEF      - default hold-duration / counter width
//   ID_W           - width of the binary winner index (covers up to 4 requesters)
//   id_to_onehot() - helper turning a winner index into a 4-bit one-hot
// Optional feature macro used by the top: ZJH_TIMER_ARB_RR_EN
// ---------------------------------------------------------------------------
package zjh_timer_arb_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam int N_REQ_DEF = 4;
  localparam int CNT_W_DEF = 4;
  localparam int ID_W      = 2;

  function automatic logic [3:0] id_to_onehot(input logic [ID_W-1:0] id);
    logic [3:0] oh;
    oh = 4'b0001 << id;
    return oh;
  endfunction

endpackage

// File: rtl/zjh_cnt_dn.sv
// ---------------------------------------------------------------------------
// zjh_cnt_dn
// Loadable down-counter shared by all grants. Loading has priority over
// decrementing, and decrementing saturates at zero so the count never wraps.
// Ports:
//   Clk      - clock, rising edge
//   Clr_N    - asynchronous active-low clear (count forced to 0)
//   Load     - synchronous load of Load_val
//   Load_val - value to load
//   Dec_en   - decrement by one when nonzero
//   Cnt      - current count
//   Zero     - high when Cnt == 0
// ---------------------------------------------------------------------------
module zjh_cnt_dn #(
  parameter int W = 4
) (
  input  logic         Clk,
  input  logic         Clr_N,
  input  logic         Load,
  input  logic [W-1:0] Load_val,
  input  logic         Dec_en,
  output logic [W-1:0] Cnt,
  output logic         Zero
);

  logic [W-1:0] cnt_reg;
  logic [W-1:0] cnt_next;

  always_comb begin
    cnt_next = cnt_reg;
    if (Load) begin
      cnt_next = Load_val;
    end else if (Dec_en && (cnt_reg != '0)) begin
      cnt_next = cnt_reg - 1'b1;
    end
  end

  always_ff @(posedge Clk or negedge Clr_N) begin
    if (!Clr_N) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

  assign Cnt  = cnt_reg;
  assign Zero = (cnt_reg == '0);

endmodule

// File: rtl/zjh_timer_arb.sv
// ---------------------------------------------------------------------------
// zjh_timer_arb
// Timed arbiter: picks one requester while idle, holds its grant for
// Dur+1 cycles (counting the shared counter down to zero), then pulses Done.
// Dropping the granted request aborts the grant with no Done pulse.
// Arbitration happens only in IDLE, so consecutive grants are separated by
// at least one idle cycle.
//
// Build option: define ZJH_TIMER_ARB_RR_EN for round-robin arbitration
// (search starts after the last winner); otherwise fixed priority, Req[0]
// highest, and no pointer register is built.
//
// Ports:
//   Clk    - clock, rising edge
//   MR_N   - asynchronous active-low master reset
//   Req    - per-requester request, held for the whole grant
//   Dur    - packed per-requester hold durations, slice i = Dur[i*CNT_W +: CNT_W]
//   Gnt    - one-hot grant, zero when idle
//   Gnt_id - binary index of the current / last winner
//   Cnt    - remaining count of the shared counter
//   Busy   - high while in RUN
//   Done   - one-cycle pulse on normal completion
// ---------------------------------------------------------------------------
module zjh_timer_arb
  import zjh_timer_arb_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic                   Clk,
  input  logic                   MR_N,
  input  logic [N_REQ-1:0]       Req,
  input  logic [N_REQ*CNT_W-1:0] Dur,
  output logic [N_REQ-1:0]       Gnt,
  output logic [ID_W-1:0]        Gnt_id,
  output logic [CNT_W-1:0]       Cnt,
  output logic                   Busy,
  output logic                   Done
);

  // -------------------------------------------------------------------------
  // Unpack durations
  // -------------------------------------------------------------------------
  logic [CNT_W-1:0] dur_arr [N_REQ];

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_dur
      assign dur_arr[gi] = Dur[gi*CNT_W +: CNT_W];
    end
  endgenerate

  // -------------------------------------------------------------------------
  // State and registered outputs
  // -------------------------------------------------------------------------
  state_t           state_reg, state_next;
  logic [N_REQ-1:0] gnt_reg, gnt_next;
  logic [ID_W-1:0]  gnt_id_reg, gnt_id_next;
  logic             done_reg, done_next;
  logic             busy_reg;

  // Counter control
  logic             cnt_load;
  logic [CNT_W-1:0] cnt_load_val;
  logic             cnt_dec;
  logic [CNT_W-1:0] cnt_val;
  logic             cnt_zero;

  // Arbiter result
  logic             arb_valid;
  logic [ID_W-1:0]  arb_id;
  logic             grant_start;

  assign arb_valid = |Req;

  // -------------------------------------------------------------------------
  // Arbiter
  // -------------------------------------------------------------------------
`ifdef ZJH_TIMER_ARB_RR_EN
  logic [ID_W-1:0] ptr_reg;

  // Search order is ptr+1, ptr+2, ... wrapping modulo N_REQ; the first
  // requester found in that order wins.
  always_comb begin
    logic found;
    int   idx;
    arb_id = '0;
    found  = 1'b0;
    idx    = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = (int'(ptr_reg) + k) % N_REQ;
      if (!found && Req[idx]) begin
        found  = 1'b1;
        arb_id = ID_W'(idx);
      end
    end
  end

  always_ff @(posedge Clk or negedge MR_N) begin
    if (!MR_N) begin
      ptr_reg <= ID_W'(N_REQ - 1);
    end else if (grant_start) begin
      ptr_reg <= arb_id;
    end
  end
`else
  // Fixed priority: scanning downwards leaves the lowest set index.
  always_comb begin
    arb_id = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (Req[k]) begin
        arb_id = ID_W'(k);
      end
    end
  end
`endif

  // -------------------------------------------------------------------------
  // FSM next-state / output logic
  // -------------------------------------------------------------------------
  logic req_held;

  // The granted request is still present; using the one-hot grant avoids
  // indexing Req with the binary id.
  assign req_held = |(Req & gnt_reg);

  always_comb begin
    state_next   = state_reg;
    gnt_next     = gnt_reg;
    gnt_id_next  = gnt_id_reg;
    done_next    = 1'b0;
    grant_start  = 1'b0;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    cnt_dec      = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        gnt_next = '0;
        if (arb_valid) begin
          state_next   = ST_RUN;
          grant_start  = 1'b1;
          gnt_next     = N_REQ'(id_to_onehot(arb_id));
          gnt_id_next  = arb_id;
          cnt_load     = 1'b1;
          cnt_load_val = dur_arr[arb_id];
        end
      end

      ST_RUN: begin
        if (!req_held) begin
          // Abort: clear the counter by loading zero, no Done.
          state_next = ST_IDLE;
          gnt_next   = '0;
          cnt_load   = 1'b1;
        end else if (cnt_zero) begin
          state_next = ST_IDLE;
          gnt_next   = '0;
          done_next  = 1'b1;
        end else begin
          cnt_dec = 1'b1;
        end
      end

      default: begin
        state_next = ST_IDLE;
        gnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge MR_N) begin
    if (!MR_N) begin
      state_reg  <= ST_IDLE;
      gnt_reg    <= '0;
      gnt_id_reg <= '0;
      done_reg   <= 1'b0;
      busy_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      gnt_reg    <= gnt_next;
      gnt_id_reg <= gnt_id_next;
      done_reg   <= done_next;
      busy_reg   <= (state_next == ST_RUN);
    end
  end

  // -------------------------------------------------------------------------
  // Shared counter
  // -------------------------------------------------------------------------
  zjh_cnt_dn #(
    .W (CNT_W)
  ) u_cnt (
    .Clk      (Clk),
    .Clr_N    (MR_N),
    .Load     (cnt_load),
    .Load_val (cnt_load_val),
    .Dec_en   (cnt_dec),
    .Cnt      (cnt_val),
    .Zero     (cnt_zero)
  );

  assign Gnt    = gnt_reg;
  assign Gnt_id = gnt_id_reg;
  assign Cnt    = cnt_val;
  assign Busy   = busy_reg;
  assign Done   = done_reg;

endmodule

// File: tb/tb_zjh_timer_arb.sv
// ---------------------------------------------------------------------------
// tb_zjh_timer_arb
// Directed scenarios followed by randomized traffic, all compared every
// cycle against a transaction-level model of the arbiter (grant owner,
// remaining hold time, completion pulse). Define ZJH_TIMER_ARB_RR_EN for
// both bench and design to exercise round-robin arbitration.
// ---------------------------------------------------------------------------
module tb_zjh_timer_arb;

  localparam int N  = 4;
  localparam int CW = 4;

  logic            Clk;
  logic            MR_N;
  logic [N-1:0]    Req;
  logic [N*CW-1:0] Dur;
  logic [N-1:0]    Gnt;
  logic [1:0]      Gnt_id;
  logic [CW-1:0]   Cnt;
  logic            Busy;
  logic            Done;

  zjh_timer_arb #(
    .N_REQ (N),
    .CNT_W (CW)
  ) dut (
    .Clk    (Clk),
    .MR_N   (MR_N),
    .Req    (Req),
    .Dur    (Dur),
    .Gnt    (Gnt),
    .Gnt_id (Gnt_id),
    .Cnt    (Cnt),
    .Busy   (Busy),
    .Done   (Done)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: is a grant in progress, who owns it, how many more
  // decrements remain, and whether a completion just happened.
  bit           m_busy;
  int           m_id;
  int           m_left;
  bit           m_done;
  int           m_ptr;
  logic [N-1:0] m_gnt;

  // Priority order as a list of candidates; the first requesting one wins.
  function automatic int pick(input logic [N-1:0] r, input int ptr);
    int order[$];
`ifdef ZJH_TIMER_ARB_RR_EN
    for (int k = 1; k <= N; k++) order.push_back((ptr + k) % N);
`else
    for (int k = 0; k < N; k++) order.push_back(k);
`endif
    foreach (order[i]) begin
      if (r[order[i]]) return order[i];
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_busy = 0;
    m_id   = 0;
    m_left = 0;
    m_done = 0;
    m_ptr  = N - 1;
    m_gnt  = '0;
  endtask

  // Advance the model by one clock using the inputs present at the edge.
  task automatic model_clock();
    int w;
    m_done = 0;
    if (!m_busy) begin
      w = pick(Req, m_ptr);
      if (w >= 0) begin
        m_busy = 1;
        m_id   = w;
        m_ptr  = w;
        m_left = int'(Dur[w*CW +: CW]);
        m_gnt  = '0;
        m_gnt[w] = 1'b1;
        $display("[%0t] grant id=%0d dur=%0d", $time, w, m_left);
      end else begin
        m_gnt = '0;
      end
    end else if (!Req[m_id]) begin
      m_busy = 0;
      m_left = 0;
      m_gnt  = '0;
      $display("[%0t] abort id=%0d", $time, m_id);
    end else if (m_left == 0) begin
      m_busy = 0;
      m_done = 1;
      m_gnt  = '0;
      $display("[%0t] done  id=%0d", $time, m_id);
    end else begin
      m_left = m_left - 1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic check_all();
    chk("gnt",    32'(Gnt),    32'(m_gnt));
    chk("gnt_id", 32'(Gnt_id), 32'(m_id));
    chk("cnt",    32'(Cnt),    32'(m_left));
    chk("busy",   32'(Busy),   32'(m_busy));
    chk("done",   32'(Done),   32'(m_done));
    chk("onehot", 32'($countones(Gnt) <= 1), 32'd1);
  endtask

  task automatic step();
    @(posedge Clk);
    model_clock();
    #1;
    check_all();
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Assert reset between edges and check it acts without a clock.
  task automatic async_reset();
    #2;
    MR_N = 1'b0;
    model_reset();
    #1;
    check_all();
    #1;
    MR_N = 1'b1;
  endtask

  task automatic set_dur(input int i, input int v);
    Dur[i*CW +: CW] = CW'(v);
  endtask

  initial begin
    MR_N = 1'b0;
    Req  = '0;
    Dur  = '0;
    model_reset();
    #1;
    check_all();               // reset state before any clock
    #11;
    MR_N = 1'b1;
    steps(2);

    // Single request, Dur0=3: Cnt 3,2,1,0 then Done then idle
    set_dur(0, 3);
    Req = 4'b0001;
    steps(6);
    Req = '0;
    steps(2);

    // Dur=0: one-cycle grant then Done
    set_dur(1, 0);
    Req = 4'b0010;
    steps(3);
    Req = '0;
    steps(1);

    // Contention, all Dur=0, all requesting
    Dur = '0;
    Req = 4'b1111;
    steps(12);
    // Drop Req[0] (lands on a boundary where requester 0 may be granted)
    Req = 4'b1110;
    steps(8);
    Req = '0;
    steps(2);

    // Abort: Dur2=9, drop Req[2] when Cnt=6
    set_dur(2, 9);
    Req = 4'b0100;
    steps(4);                  // grant (9) then 8,7,6
    Req = '0;
    steps(3);

    // Reset mid-RUN with Cnt=5
    set_dur(1, 8);
    Req = 4'b0010;
    steps(4);                  // 8,7,6,5
    async_reset();
    steps(3);                  // grant after release follows reset state
    Req = '0;
    steps(12);

    // Max duration, with Dur changed mid-run
    set_dur(3, 15);
    Req = 4'b1000;
    steps(3);
    set_dur(3, 2);
    Req = 4'b1100;             // extra non-granted request during RUN
    steps(16);
    Req = '0;
    steps(2);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) Req = N'($urandom_range(0, (1 << N) - 1));
      if ($urandom_range(0, 7) == 0) Dur = (N*CW)'($urandom);
      if ($urandom_range(0, 149) == 0) async_reset();
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // Hard time limit so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
